prga: RTL and testbench
=======================

PRGA -- requirements
Module: prga

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset; synchronous, active-low; clock clk.
REQ-003 en  input  1  start request; honoured only in a cycle where rdy=1.
REQ-004 rdy  output  1  high only in IDLE, meaning ready for a new message.
REQ-005 s_addr  output  8  address into the S state memory, already initialised by the key-scheduling stage.
REQ-006 s_rddata  input  8  S read data, valid one cycle after s_addr is presented (synchronous RAM).
REQ-007 s_wrdata  output  8  S write data.
REQ-008 s_wren  output  1  S write enable.
REQ-009 ct_addr  output  8  ciphertext memory address.
REQ-010 ct_rddata  input  8  ciphertext read data, one-cycle latency.
REQ-011 pt_addr  output  8  plaintext memory address.
REQ-012 pt_wrdata  output  8  plaintext write data.
REQ-013 pt_wren  output  1  plaintext write enable.

Function
REQ-014 Message format SHALL be length-prefixed: ct[0]=L (0..255), ct[1..L]=bytes; output pt[0]=L, pt[k]=ct[k] XOR pad_k.
REQ-015 Internal registers SHALL be i, j, k, L, si, sj (8 bits each); all sums SHALL wrap mod 256 with no carry kept.
REQ-016 Outputs SHALL be Moore (decoded from state and registers); s_wren and pt_wren SHALL be 0 outside the states named below.
REQ-017 IDLE: rdy=1; if en=1, clear i, j and k, then go to LEN_RD.
REQ-018 LEN_RD: ct_addr=0; go to LEN_WR.
REQ-019 LEN_WR: latch L=ct_rddata; write pt[0]=ct_rddata; if ct_rddata=0, go to IDLE, else k<=1, i<=1, go to RD_I.
REQ-020 RD_I: s_addr=i; go to RD_J.
REQ-021 RD_J: si<=s_rddata; j<=j+s_rddata; s_addr=j+s_rddata (combinational from rddata); go to WR_I.
REQ-022 WR_I: sj<=s_rddata; write S[i]=s_rddata; go to WR_J.
REQ-023 WR_J: write S[j]=si; go to RD_PAD.
REQ-024 RD_PAD: s_addr=si+sj; ct_addr=k; go to XOR.
REQ-025 XOR: write pt[k]=s_rddata XOR ct_rddata; if k=L go to IDLE, else k<=k+1, i<=i+1, go to RD_I.
REQ-026 Latency SHALL be exactly 2+6L cycles with rdy=0, counted from the cycle after en is accepted.
REQ-027 en SHALL be ignored while rdy=0; holding en high in IDLE SHALL immediately start the next message.
REQ-028 When i=j, the swap SHALL leave S unchanged, with the WR_J value winning.
REQ-029 L=255 SHALL complete without k or i overflow aliasing: k stops at 255.
REQ-030 Read-after-write on S is allowed: the RD_PAD read SHALL observe the WR_J write.
REQ-031 An unreachable state encoding SHALL go to IDLE with all write enables at 0.

Reset
REQ-032 With rst_n=0 at a clock edge, the state SHALL become IDLE and i, j, k, L, si, sj SHALL become 0.
REQ-033 In the cycle after reset: rdy=1, all addresses 0, all wrdata 0, s_wren=0, pt_wren=0.
REQ-034 Reset mid-message SHALL abort with no further memory writes; memory contents are not restored.

Structure
REQ-035 Package arc4_pkg SHALL hold the prga_state_t enum and the constant MSG_LEN_ADDR=8'd0.
REQ-036 There SHALL be no sub-module; the S, ct and pt port muxing SHALL be inline in prga.

Verification (S preloaded with the identity permutation S[x]=x unless stated)
REQ-037 ct={3,00,00,00}, pulse en -> pt={3,02,05,07}; afterwards S[2]=03, S[3]=05, S[5]=02.
REQ-038 ct={0}, pulse en -> pt[0]=0; no s_wren pulse; rdy low for exactly 2 cycles.
REQ-039 ct={3,AA,BB,CC} -> pt={3,A8,BE,CB}; rdy low for exactly 20 cycles.
REQ-040 Assert rst_n=0 in the 9th busy cycle -> next cycle rdy=1 and both write enables 0; pt[2..3] untouched.
REQ-041 Hold en=1 for 2 messages back-to-back -> the second message starts in the cycle rdy returns high; en pulses while busy have no effect.
REQ-042 S preloaded with a known KSA output, L=255 -> pt matches the golden software ARC4 model byte for byte.

Source files
------------

// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: PRGA state encoding and fixed memory locations.
// Imported by the keystream generator (prga).
package arc4_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LEN_RD = 4'd1,
    LEN_WR = 4'd2,
    RD_I   = 4'd3,
    RD_J   = 4'd4,
    WR_I   = 4'd5,
    WR_J   = 4'd6,
    RD_PAD = 4'd7,
    XOR    = 4'd8
  } prga_state_t;

  // The message length byte lives at the start of both ct and pt memories.
  localparam logic [7:0] MSG_LEN_ADDR = 8'd0;

endpackage

// File: rtl/prga.sv
// ARC4 pseudo-random generation stage: decrypts a length-prefixed ciphertext
// against an already key-scheduled S memory, six cycles per message byte.
module prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  prga_state_t state_q, state_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  j_q, j_d;
  logic [7:0]  k_q, k_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  si_q, si_d;
  logic [7:0]  sj_q, sj_d;
  logic [7:0]  jNext;

  // j advances by S[i], which only arrives from the RAM during RD_J.
  assign jNext = j_q + s_rddata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= 8'd0;
      j_q     <= 8'd0;
      k_q     <= 8'd0;
      len_q   <= 8'd0;
      si_q    <= 8'd0;
      sj_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    rdy       = 1'b0;
    s_addr    = 8'd0;
    s_wrdata  = 8'd0;
    s_wren    = 1'b0;
    ct_addr   = 8'd0;
    pt_addr   = 8'd0;
    pt_wrdata = 8'd0;
    pt_wren   = 1'b0;

    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          k_d     = 8'd0;
          state_d = LEN_RD;
        end
      end
      LEN_RD: begin
        ct_addr = MSG_LEN_ADDR;
        state_d = LEN_WR;
      end
      LEN_WR: begin
        len_d     = ct_rddata;
        pt_addr   = MSG_LEN_ADDR;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        if (ct_rddata == 8'd0) begin
          state_d = IDLE;
        end else begin
          k_d     = 8'd1;
          i_d     = 8'd1;
          state_d = RD_I;
        end
      end
      RD_I: begin
        s_addr  = i_q;
        state_d = RD_J;
      end
      RD_J: begin
        si_d    = s_rddata;
        j_d     = jNext;
        s_addr  = jNext;
        state_d = WR_I;
      end
      // Swap is two writes; when i==j the WR_J write of si restores the byte.
      WR_I: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = WR_J;
      end
      WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = RD_PAD;
      end
      RD_PAD: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = XOR;
      end
      XOR: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        // Stopping on k==len before incrementing keeps k and i from wrapping at 255.
        if (k_q == len_q) begin
          state_d = IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          i_d     = i_q + 8'd1;
          state_d = RD_I;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: memories modelled around the DUT, software ARC4
// reference predicting every S/pt write and the ready/busy timing.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  logic [7:0] smem   [256];
  logic [7:0] ctmem  [256];
  logic [7:0] ptmem  [256];
  logic [7:0] smodel [256];
  logic [7:0] expPt  [256];
  logic [15:0] expPtQ[$];
  logic [15:0] expSQ[$];
  logic [15:0] expW;

  int checks    = 0;
  int failures  = 0;
  bit chkOn     = 1'b0;
  int busyLeft  = 0;
  int runLen    = 0;
  int busyRuns[$];
  int sWrCount  = 0;

  always #5 clk = ~clk;

  prga dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  // Synchronous RAMs with one-cycle read latency; reads see the pre-write value.
  always @(posedge clk) begin
    s_rddata  <= smem[s_addr];
    ct_rddata <= ctmem[ct_addr];
    if (s_wren === 1'b1) smem[s_addr] = s_wrdata;
    if (pt_wren === 1'b1) ptmem[pt_addr] = pt_wrdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Software ARC4 keystream over the whole message, run when a start is accepted.
  task automatic modelMessage();
    logic [7:0] len, i, j, si, sj, pad, pt;
    len = ctmem[0];
    expPt[0] = len;
    expPtQ.push_back({8'h00, len});
    i = 8'd0;
    j = 8'd0;
    for (int k = 1; k <= int'(len); k++) begin
      i = i + 8'd1;
      si = smodel[i];
      j = j + si;
      sj = smodel[j];
      expSQ.push_back({i, sj});
      expSQ.push_back({j, si});
      smodel[i] = sj;
      smodel[j] = si;
      pad = smodel[8'(si + sj)];
      pt = ctmem[k] ^ pad;
      expPt[k] = pt;
      expPtQ.push_back({8'(k), pt});
    end
  endtask

  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      busyLeft = 0;
      expPtQ.delete();
      expSQ.delete();
    end else if (busyLeft > 0) begin
      busyLeft = busyLeft - 1;
    end else if (en === 1'b1) begin
      modelMessage();
      busyLeft = 2 + 6 * int'(ctmem[0]);
    end
  end

  always @(negedge clk) begin
    if (chkOn) begin
      checkOutput("rdy", 32'(rdy), 32'(busyLeft == 0));
      if (pt_wren !== 1'b0) begin
        if (expPtQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL ptWriteUnexpected actual=%0h expected=none", {pt_addr, pt_wrdata});
        end else begin
          expW = expPtQ.pop_front();
          checkOutput("ptWrite", 32'({pt_addr, pt_wrdata}), 32'(expW));
        end
      end
      if (s_wren !== 1'b0) begin
        sWrCount++;
        if (expSQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL sWriteUnexpected actual=%0h expected=none", {s_addr, s_wrdata});
        end else begin
          expW = expSQ.pop_front();
          checkOutput("sWrite", 32'({s_addr, s_wrdata}), 32'(expW));
        end
      end
      if (rdy === 1'b0) begin
        runLen++;
      end else if (runLen > 0) begin
        busyRuns.push_back(runLen);
        runLen = 0;
      end
    end
  end

  task automatic loadIdentity();
    for (int x = 0; x < 256; x++) begin
      smem[x]   = 8'(x);
      smodel[x] = 8'(x);
    end
  endtask

  // KSA for key "Key" so the literal RC4 test vector applies.
  task automatic loadKsa();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h4B;
    key[1] = 8'h65;
    key[2] = 8'h79;
    for (int x = 0; x < 256; x++) smodel[x] = 8'(x);
    j = 8'd0;
    for (int x = 0; x < 256; x++) begin
      j = j + smodel[x] + key[x % 3];
      t = smodel[x];
      smodel[x] = smodel[j];
      smodel[j] = t;
    end
    for (int x = 0; x < 256; x++) smem[x] = smodel[x];
  endtask

  task automatic fillPt(input logic [7:0] v);
    for (int x = 0; x < 256; x++) ptmem[x] = v;
  endtask

  task automatic setCt4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    ctmem[0] = a;
    ctmem[1] = b;
    ctmem[2] = c;
    ctmem[3] = d;
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (rdy !== 1'b1 && n < budget) begin
      n++;
      @(negedge clk);
    end
    checkOutput("idleWithinBudget", 32'(rdy), 32'd1);
    #1;
  endtask

  task automatic checkBusy(input int idx, input int expLen);
    checkOutput("busyRunCount", 32'(busyRuns.size() > idx), 32'd1);
    if (busyRuns.size() > idx) checkOutput("busyCycles", 32'(busyRuns[idx]), 32'(expLen));
  endtask

  task automatic checkMessage(input int len);
    checkOutput("ptQueueDrained", 32'(expPtQ.size()), 32'd0);
    checkOutput("sQueueDrained", 32'(expSQ.size()), 32'd0);
    for (int k = 0; k <= len; k++) checkOutput("ptMem", 32'(ptmem[k]), 32'(expPt[k]));
    for (int x = 0; x < 256; x++) checkOutput("sMem", 32'(smem[x]), 32'(smodel[x]));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    logic [7:0] plain [9];
    rst_n = 1'b0;
    en    = 1'b0;
    for (int x = 0; x < 256; x++) ctmem[x] = 8'd0;
    fillPt(8'h00);
    loadIdentity();

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetRdy", 32'(rdy), 32'd1);
    checkOutput("resetSAddr", 32'(s_addr), 32'd0);
    checkOutput("resetCtAddr", 32'(ct_addr), 32'd0);
    checkOutput("resetPtAddr", 32'(pt_addr), 32'd0);
    checkOutput("resetSWrdata", 32'(s_wrdata), 32'd0);
    checkOutput("resetPtWrdata", 32'(pt_wrdata), 32'd0);
    checkOutput("resetSWren", 32'(s_wren), 32'd0);
    checkOutput("resetPtWren", 32'(pt_wren), 32'd0);
    chkOn = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero ciphertext against identity S exposes the raw keystream 2,5,7
    $display("[TB] identity S, zero ciphertext");
    loadIdentity();
    setCt4(8'd3, 8'h00, 8'h00, 8'h00);
    fillPt(8'hEE);
    busyRuns.delete();
    applyStimulus();
    waitIdle(4000);
    checkOutput("litPt0", 32'(ptmem[0]), 32'h03);
    checkOutput("litPt1", 32'(ptmem[1]), 32'h02);
    checkOutput("litPt2", 32'(ptmem[2]), 32'h05);
    checkOutput("litPt3", 32'(ptmem[3]), 32'h07);
    checkOutput("litS2", 32'(smem[2]), 32'h03);
    checkOutput("litS3", 32'(smem[3]), 32'h05);
    checkOutput("litS5", 32'(smem[5]), 32'h02);
    checkBusy(0, 20);
    checkMessage(3);

    // Empty message
    $display("[TB] empty message");
    ctmem[0] = 8'd0;
    fillPt(8'hFF);
    busyRuns.delete();
    sWrCount = 0;
    applyStimulus();
    waitIdle(4000);
    checkOutput("emptyPt0", 32'(ptmem[0]), 32'h00);
    checkOutput("emptySWrites", 32'(sWrCount), 32'd0);
    checkBusy(0, 2);
    checkMessage(0);

    // Nonzero ciphertext with identity S
    $display("[TB] identity S, AA BB CC");
    loadIdentity();
    setCt4(8'd3, 8'hAA, 8'hBB, 8'hCC);
    fillPt(8'h11);
    busyRuns.delete();
    applyStimulus();
    waitIdle(4000);
    checkOutput("litPtA8", 32'(ptmem[1]), 32'hA8);
    checkOutput("litPtBE", 32'(ptmem[2]), 32'hBE);
    checkOutput("litPtCB", 32'(ptmem[3]), 32'hCB);
    checkBusy(0, 20);
    checkMessage(3);

    // Reset in the 9th busy cycle aborts before pt[2]
    $display("[TB] reset mid-message");
    loadIdentity();
    setCt4(8'd3, 8'hAA, 8'hBB, 8'hCC);
    fillPt(8'h5A);
    applyStimulus();
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abortRdy", 32'(rdy), 32'd1);
    checkOutput("abortSWren", 32'(s_wren), 32'd0);
    checkOutput("abortPtWren", 32'(pt_wren), 32'd0);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("abortPt0", 32'(ptmem[0]), 32'h03);
    checkOutput("abortPt1", 32'(ptmem[1]), 32'hA8);
    checkOutput("abortPt2", 32'(ptmem[2]), 32'h5A);
    checkOutput("abortPt3", 32'(ptmem[3]), 32'h5A);

    // en held high across two messages, plus ignored pulses while busy
    $display("[TB] back-to-back messages");
    loadIdentity();
    ctmem[0] = 8'd4;
    for (int k = 1; k <= 4; k++) ctmem[k] = 8'($urandom);
    fillPt(8'h33);
    busyRuns.delete();
    @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    waitIdle(4000);
    @(posedge clk);
    #1 en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 en = 1'b1;
      @(posedge clk);
      #1 en = 1'b0;
    end
    waitIdle(4000);
    checkOutput("b2bRuns", 32'(busyRuns.size()), 32'd2);
    checkBusy(0, 26);
    checkBusy(1, 26);
    checkMessage(4);

    // Randomized messages, S carried over between them
    $display("[TB] random messages");
    loadIdentity();
    for (int m = 0; m < 10; m++) begin
      len = (m == 3) ? 0 : int'($urandom_range(1, 24));
      ctmem[0] = 8'(len);
      for (int k = 1; k <= len; k++) ctmem[k] = 8'($urandom);
      fillPt(8'($urandom));
      busyRuns.delete();
      repeat ($urandom_range(0, 3)) @(posedge clk);
      applyStimulus();
      waitIdle(4000);
      checkBusy(0, 2 + 6 * len);
      checkMessage(len);
    end

    // Known RC4 vector: key "Key", plaintext "Plaintext"
    $display("[TB] KSA-loaded S, RC4 test vector");
    loadKsa();
    ctmem[0] = 8'd9;
    ctmem[1] = 8'hBB; ctmem[2] = 8'hF3; ctmem[3] = 8'h16;
    ctmem[4] = 8'hE8; ctmem[5] = 8'hD9; ctmem[6] = 8'h40;
    ctmem[7] = 8'hAF; ctmem[8] = 8'h0A; ctmem[9] = 8'hD3;
    plain[0] = 8'h50; plain[1] = 8'h6C; plain[2] = 8'h61;
    plain[3] = 8'h69; plain[4] = 8'h6E; plain[5] = 8'h74;
    plain[6] = 8'h65; plain[7] = 8'h78; plain[8] = 8'h74;
    fillPt(8'h00);
    applyStimulus();
    waitIdle(4000);
    for (int k = 0; k < 9; k++) checkOutput("rc4Vector", 32'(ptmem[k + 1]), 32'(plain[k]));
    checkMessage(9);

    // Longest message: k must stop at 255
    $display("[TB] KSA-loaded S, 255-byte message");
    loadKsa();
    ctmem[0] = 8'd255;
    for (int k = 1; k < 256; k++) ctmem[k] = 8'($urandom);
    fillPt(8'h00);
    busyRuns.delete();
    applyStimulus();
    waitIdle(4000);
    checkBusy(0, 2 + 6 * 255);
    checkMessage(255);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
